// File: rtl/regfile_dual_read_if.sv
// Register-file access bundle: one write port, two loaded read ports.
// The master drives indices and enables; the slave returns A, B and err.
interface regfile_dual_read_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
);
    logic              write;
    logic [ADDR_W-1:0] writenum;
    logic [WIDTH-1:0]  data_in;
    logic [ADDR_W-1:0] readnum_a;
    logic [ADDR_W-1:0] readnum_b;
    logic              loada;
    logic              loadb;
    logic [WIDTH-1:0]  A;
    logic [WIDTH-1:0]  B;
    logic              err;

    modport master (
        output write,
        output writenum,
        output data_in,
        output readnum_a,
        output readnum_b,
        output loada,
        output loadb,
        input  A,
        input  B,
        input  err
    );

    modport slave (
        input  write,
        input  writenum,
        input  data_in,
        input  readnum_a,
        input  readnum_b,
        input  loada,
        input  loadb,
        output A,
        output B,
        output err
    );
endinterface

// File: rtl/regfile_dual_read.sv
// Register file with one write port and two registered read ports,
// same-edge write-through bypass, optional hardwired zero r0, sticky err.
module regfile_dual_read #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 3,
    parameter bit ZERO_R0 = 1'b0
) (
    input logic               clk,
    input logic               reset,
    regfile_dual_read_if.slave bus
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             err_q;

    logic             wr_in_range;
    logic             wr_ok;
    logic             rd_a_in_range;
    logic             rd_b_in_range;
    logic [WIDTH-1:0] rd_a_val;
    logic [WIDTH-1:0] rd_b_val;
    logic             err_set;

    function automatic logic in_range(input logic [ADDR_W-1:0] idx);
        return int'(idx) < DEPTH;
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] idx);
        return ZERO_R0 && (idx == '0);
    endfunction

    always_comb begin
        wr_in_range   = in_range(bus.writenum);
        rd_a_in_range = in_range(bus.readnum_a);
        rd_b_in_range = in_range(bus.readnum_b);
        wr_ok = bus.write && wr_in_range
              && !is_zero_reg(bus.writenum);
    end

    // Read mux: out-of-range and hardwired r0 yield zero; a same-edge
    // write to the addressed register is forwarded ahead of the array.
    always_comb begin
        rd_a_val = '0;
        if (rd_a_in_range && !is_zero_reg(bus.readnum_a)) begin
            if (wr_ok && bus.writenum == bus.readnum_a)
                rd_a_val = bus.data_in;
            else
                rd_a_val = mem[bus.readnum_a];
        end
    end

    always_comb begin
        rd_b_val = '0;
        if (rd_b_in_range && !is_zero_reg(bus.readnum_b)) begin
            if (wr_ok && bus.writenum == bus.readnum_b)
                rd_b_val = bus.data_in;
            else
                rd_b_val = mem[bus.readnum_b];
        end
    end

    // Only enabled accesses can flag an error.
    always_comb begin
        err_set = (bus.write && !wr_in_range)
                | (bus.loada && !rd_a_in_range)
                | (bus.loadb && !rd_b_in_range);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wr_ok) begin
            mem[bus.writenum] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            err_q <= 1'b0;
        end else begin
            if (bus.loada)
                a_q <= rd_a_val;
            if (bus.loadb)
                b_q <= rd_b_val;
            if (err_set)
                err_q <= 1'b1;
        end
    end

    assign bus.A   = a_q;
    assign bus.B   = b_q;
    assign bus.err = err_q;
endmodule

// File: doc/regfile_dual_read.md
REGFILE_DUAL_READ -- requirements
Module: regfile_dual_read

Interface
REQ-001 Parameter: WIDTH, default 16, data bit width of every register and of A/B.
REQ-002 Parameter: DEPTH, default 8, number of registers (2..256, need not be a power of two).
REQ-003 Parameter: ADDR_W, default 3, register index width; SHALL satisfy 2^ADDR_W >= DEPTH.
REQ-004 Parameter: ZERO_R0, default 0, when 1 register 0 reads as zero and ignores writes.
REQ-005 Port: clk  input  1  single rising-edge clock for all state.
REQ-006 Port: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-007 Port: write  input  1  write enable for the register array.
REQ-008 Port: writenum  input  ADDR_W  index of register written.
REQ-009 Port: data_in  input  WIDTH  write data.
REQ-010 Port: readnum_a  input  ADDR_W  index read into A.
REQ-011 Port: readnum_b  input  ADDR_W  index read into B.
REQ-012 Port: loada  input  1  capture enable for A.
REQ-013 Port: loadb  input  1  capture enable for B.
REQ-014 Port: A  output  WIDTH  registered operand A.
REQ-015 Port: B  output  WIDTH  registered operand B.
REQ-016 Port: err  output  1  registered sticky flag, set on any out-of-range access.

Function
REQ-017 Array SHALL hold DEPTH registers of WIDTH bits; all state updates on rising clk only.
REQ-018 Write: when write=1 and writenum<DEPTH (and not register 0 with ZERO_R0=1), reg[writenum] <= data_in at the edge.
REQ-019 Read ports A and B SHALL be fully independent; both may address the same register in one cycle.
REQ-020 A SHALL update only on an edge with loada=1; otherwise A holds. Same for B with loadb.
REQ-021 Read latency: value captured into A/B at edge N is visible on A/B immediately after edge N (one cycle from readnum/load to output).
REQ-022 Write-through bypass: if write=1, loada=1 and writenum==readnum_a (valid, writable index) on the same edge, A SHALL capture data_in, not the old contents; same rule for B.
REQ-023 Without a same-edge collision, A/B capture the array contents as of before the edge.
REQ-024 ZERO_R0=1: reads of index 0 SHALL return all zeros, including during a write to index 0 (no bypass to register 0).
REQ-025 Out-of-range read (readnum >= DEPTH) with its load=1: captured value SHALL be all zeros and err SHALL set.
REQ-026 Out-of-range write (writenum >= DEPTH) with write=1: array unchanged and err SHALL set.
REQ-027 err SHALL remain 1 until reset; err never clears otherwise.
REQ-028 Out-of-range indices with their enable low SHALL have no effect and SHALL NOT set err.
REQ-029 No X SHALL ever be driven on A, B or err after the first reset edge, for any input combination.

Reset
REQ-030 reset=1 at an edge SHALL clear every array register, A, B and err to 0, overriding write, loada and loadb on that edge.
REQ-031 Reset mid-sequence SHALL discard any same-edge write or load; the first edge with reset=0 behaves as normal operation on zeroed state.
REQ-032 Before the first reset edge, output values are unspecified.

Verification
REQ-033 Reset then loada=loadb=1, readnum_a=3, readnum_b=5 -> A=0x0000, B=0x0000, err=0.
REQ-034 Write 0xBEEF to reg2, next cycle readnum_a=2 loada=1 -> A=0xBEEF one edge later; B unchanged with loadb=0.
REQ-035 Same edge: write=1 writenum=4 data_in=0x1234, readnum_a=readnum_b=4, loada=loadb=1 -> A=B=0x1234 after that edge.
REQ-036 ZERO_R0=1: write 0xFFFF to reg0 with loada=1 readnum_a=0 on same edge -> A=0x0000; subsequent read of reg0 also 0x0000.
REQ-037 DEPTH=6: write to index 7 then loada=1 readnum_a=6 -> array unchanged, A=0x0000, err=1 and held until reset; reset -> err=0.
REQ-038 Write 0xAAAA to reg1, then reset asserted on the edge with write=1 data_in=0x5555 to reg1 -> reg1=0x0000, A=B=0x0000.
